or4x4_arb: RTL

OR4X4_ARB -- requirements
Module: or4x4_arb

---
 rtl/or4x4_arb.sv | 96 +++++++++
 1 files changed

// File: rtl/or4x4_arb.sv
// Round-robin arbiter over four requesters; the granted operand set is OR-reduced
// into a single-entry output register that honours O_READY backpressure.
module or4x4_arb #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               ASYNCRESET,
    input  logic [3:0]         REQ,
    input  logic [4*WIDTH-1:0] I0,
    input  logic [4*WIDTH-1:0] I1,
    input  logic [4*WIDTH-1:0] I2,
    input  logic [4*WIDTH-1:0] I3,
    output logic [3:0]         GNT,
    output logic [WIDTH-1:0]   O,
    output logic               O_VALID,
    output logic [1:0]         O_ID,
    input  logic               O_READY,
    output logic [7:0]         COUNT
);

    logic [1:0]         ptr;
    logic               free;
    logic               deliver;
    logic               grant_any;
    logic [1:0]         grant_idx;
    logic [4*WIDTH-1:0] grant_set;
    logic [WIDTH-1:0]   grant_or;

    // The slot accepts a new result when empty or when the current one leaves this cycle.
    assign free    = !O_VALID || O_READY;
    assign deliver = O_VALID && O_READY;

    // Search order starts at ptr; 2-bit index arithmetic wraps modulo 4.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant_any = 1'b0;
        grant_idx = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!grant_any && REQ[ptr + 2'(i)]) begin
                grant_any = 1'b1;
                grant_idx = ptr + 2'(i);
            end
        end
        if (!free || ASYNCRESET) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        GNT = '0;
        if (grant_any) begin
            GNT[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    grant_set = I0;
            2'd1:    grant_set = I1;
            2'd2:    grant_set = I2;
            default: grant_set = I3;
        endcase
    end

    always_comb begin
        grant_or = '0;
        for (int j = 0; j < 4; j++) begin
            grant_or = grant_or | grant_set[j*WIDTH +: WIDTH];
        end
    end

    // A grant in the same cycle as a delivery reloads the slot, so O_VALID never bubbles.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            O       <= '0;
            O_ID    <= 2'd0;
            O_VALID <= 1'b0;
            ptr     <= 2'd0;
            COUNT   <= 8'd0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            if (grant_any) begin
                O       <= grant_or;
                O_ID    <= grant_idx;
                O_VALID <= 1'b1;
                ptr     <= grant_idx + 2'd1;
            end else if (deliver) begin
                O_VALID <= 1'b0;
            end
            if (deliver) begin
                COUNT <= COUNT + 8'd1;
            end
        end
    end

endmodule
